// File: rtl/seg_pkg.sv
// seg_pkg: shared code type and active-low segment patterns (a..g on bits 6..0).
package seg_pkg;
  typedef logic [3:0] code_t;
  typedef logic [6:0] seg_t;
  localparam code_t CODE_BLANK = 4'hF;
  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: data, strobe and display pins of the scan driver.
interface seven_seg_scan_driver_if #(parameter int DIGITS = 4);
  logic en;
  logic load;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0] dp_in;
  logic [6:0] seg;
  logic dp;
  logic [DIGITS-1:0] an;
  logic pending;
  logic frame;
  modport master (output en, load, bcd, dp_in, input seg, dp, an, pending, frame);
  modport slave (input en, load, bcd, dp_in, output seg, dp, an, pending, frame);
endinterface

// File: rtl/bcd_seg_lut.sv
// bcd_seg_lut: combinational code-to-segment map, codes 10..15 blank.
module bcd_seg_lut
  import seg_pkg::*;
(
  input  code_t code,
  output seg_t  seg
);
  always_comb
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed 7-segment scanner with tear-free shadow load.
// Optional leading-zero blanking compiled in with SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV = 1000
) (
  input logic clk,
  input logic rst,
  seven_seg_scan_driver_if.slave bus
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  code_t [DIGITS-1:0] act_q, act_d, shd_q, shd_d;
  logic [DIGITS-1:0] adp_q, adp_d, sdp_q, sdp_d;
  logic pending_q, pending_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg_t seg_q, seg_d, lut_seg;
  logic dp_q, dp_d;
  logic step, wrap, blank_sel;
  code_t code_sel;
  always_comb begin
    step = bus.en && cnt_q == CW'(DIV - 1);
    wrap = step && idx_q == IW'(DIGITS - 1);
    cnt_d = !bus.en ? cnt_q : step ? '0 : cnt_q + 1'b1;
    idx_d = !step ? idx_q : wrap ? '0 : idx_q + 1'b1;
    shd_d = bus.load ? bus.bcd : shd_q;
    sdp_d = bus.load ? bus.dp_in : sdp_q;
    // active only changes at the frame boundary so a frame never mixes old and new data
    act_d = wrap && pending_q ? shd_q : act_q;
    adp_d = wrap && pending_q ? sdp_q : adp_q;
    pending_d = bus.load | (pending_q & ~wrap);
  end
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = act_q[DIGITS-1] == 4'd0;
    for (int i = DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] && act_q[i] == 4'd0;
    blank_sel = idx_q != '0 && lz[idx_q];
  end
`else
  assign blank_sel = 1'b0;
`endif
  assign code_sel = blank_sel ? CODE_BLANK : act_q[idx_q];
  bcd_seg_lut u_lut (.code(code_sel), .seg(lut_seg));
  always_comb begin
    an_d = bus.en ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d = bus.en ? lut_seg : SEG_BLANK;
    dp_d = bus.en ? ~adp_q[idx_q] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      act_q <= '1;
      shd_q <= '1;
      adp_q <= '0;
      sdp_q <= '0;
      pending_q <= 1'b0;
      an_q <= '1;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      act_q <= act_d;
      shd_q <= shd_d;
      adp_q <= adp_d;
      sdp_q <= sdp_d;
      pending_q <= pending_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.pending = pending_q;
  assign bus.frame = wrap;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed checks of scan, load, enable and blanking with DIGITS=4, DIV=4.
module tb_seven_seg_scan_driver;
  localparam int DIGITS = 4;
  localparam int DIV = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'b1111111;
`else
  localparam logic [6:0] LZ_SEG = 7'b0000001;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  int k = 0;
  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus();
  seven_seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.bcd = '0;
    bus.dp_in = '0;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
  endtask

  task automatic start_scan();
    bus.en = 1'b1;
    k = 0;
  endtask

  task automatic load_now(input logic [15:0] b, input logic [3:0] d);
    bus.bcd = b;
    bus.dp_in = d;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    start_scan();
    load_now(16'h1234, 4'hF);
    run_to(6);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL rst_an got %b want 1111", bus.an); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL rst_seg got %b want 1111111", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL rst_dp got %b want 1", bus.dp); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", bus.pending); end
    checks++; if (bus.frame !== 1'b0) begin errors++; $display("FAIL rst_frame got %b want 0", bus.frame); end
    @(negedge clk);
    rst = 1'b0;
    start_scan();
    tick();
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL post_rst_an got %b want 1110", bus.an); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL post_rst_seg got %b want 1111111", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL post_rst_dp got %b want 1", bus.dp); end
    run_to(17);
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL rst_discard_seg got %b want 1111111", bus.seg); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL rst_discard_pending got %b want 0", bus.pending); end
  endtask

  task automatic test_scan();
    int frames;
    logic [3:0] exp_an;
    frames = 0;
    do_reset();
    start_scan();
    for (int i = 1; i <= 32; i++) begin
      tick();
      exp_an = ~(4'b0001 << (((i - 1) / 4) % 4));
      if (bus.frame === 1'b1) frames++;
      checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL scan_an cyc %0d got %b want %b", i, bus.an, exp_an); end
      checks++; if (bus.frame !== (i % 16 == 15)) begin errors++; $display("FAIL scan_frame cyc %0d got %b want %b", i, bus.frame, i % 16 == 15); end
    end
    checks++; if (frames != 2) begin errors++; $display("FAIL scan_frame_count got %0d want 2", frames); end
  endtask

  task automatic test_load();
    do_reset();
    start_scan();
    run_to(5);
    load_now(16'h1234, 4'h0);
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL load_pending got %b want 1", bus.pending); end
    run_to(15);
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL load_old_seg got %b want 1111111", bus.seg); end
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL load_pending_hold got %b want 1", bus.pending); end
    run_to(16);
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL load_tearfree_seg got %b want 1111111", bus.seg); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL load_pending_clr got %b want 0", bus.pending); end
    run_to(17);
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL load_d0_an got %b want 1110", bus.an); end
    checks++; if (bus.seg !== 7'b1001100) begin errors++; $display("FAIL load_d0_seg got %b want 1001100", bus.seg); end
    run_to(21);
    checks++; if (bus.seg !== 7'b0000110) begin errors++; $display("FAIL load_d1_seg got %b want 0000110", bus.seg); end
    run_to(25);
    checks++; if (bus.seg !== 7'b0010010) begin errors++; $display("FAIL load_d2_seg got %b want 0010010", bus.seg); end
    run_to(29);
    checks++; if (bus.an !== 4'b0111) begin errors++; $display("FAIL load_d3_an got %b want 0111", bus.an); end
    checks++; if (bus.seg !== 7'b1001111) begin errors++; $display("FAIL load_d3_seg got %b want 1001111", bus.seg); end
  endtask

  task automatic test_invalid_enable();
    do_reset();
    load_now(16'hA9B0, 4'h0);
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL inv_pending got %b want 1", bus.pending); end
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL inv_off_an got %b want 1111", bus.an); end
    start_scan();
    run_to(17);
    checks++; if (bus.seg !== 7'b0000001) begin errors++; $display("FAIL inv_d0_seg got %b want 0000001", bus.seg); end
    run_to(21);
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL inv_d1_seg got %b want 1111111", bus.seg); end
    checks++; if (bus.an !== 4'b1101) begin errors++; $display("FAIL inv_d1_an got %b want 1101", bus.an); end
    run_to(22);
    bus.en = 1'b0;
    tick();
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL en0_an got %b want 1111", bus.an); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL en0_seg got %b want 1111111", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL en0_dp got %b want 1", bus.dp); end
    checks++; if (bus.frame !== 1'b0) begin errors++; $display("FAIL en0_frame got %b want 0", bus.frame); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL en0_hold_an %0d got %b want 1111", i, bus.an); end
    end
    bus.en = 1'b1;
    tick();
    checks++; if (bus.an !== 4'b1101) begin errors++; $display("FAIL resume1_an got %b want 1101", bus.an); end
    tick();
    checks++; if (bus.an !== 4'b1101) begin errors++; $display("FAIL resume2_an got %b want 1101", bus.an); end
    tick();
    checks++; if (bus.an !== 4'b1011) begin errors++; $display("FAIL resume3_an got %b want 1011", bus.an); end
    checks++; if (bus.seg !== 7'b0000100) begin errors++; $display("FAIL inv_d2_seg got %b want 0000100", bus.seg); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.an !== 4'b0111) begin errors++; $display("FAIL inv_d3_an got %b want 0111", bus.an); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL inv_d3_seg got %b want 1111111", bus.seg); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_now(16'h1111, 4'h0);
    start_scan();
    run_to(15);
    checks++; if (bus.frame !== 1'b1) begin errors++; $display("FAIL b2b_frame got %b want 1", bus.frame); end
    load_now(16'h2222, 4'h0);
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL b2b_pending got %b want 1", bus.pending); end
    tick();
    checks++; if (bus.seg !== 7'b1001111) begin errors++; $display("FAIL b2b_first_seg got %b want 1001111", bus.seg); end
    run_to(29);
    checks++; if (bus.seg !== 7'b1001111) begin errors++; $display("FAIL b2b_d3_seg got %b want 1001111", bus.seg); end
    run_to(31);
    checks++; if (bus.frame !== 1'b1) begin errors++; $display("FAIL b2b_frame2 got %b want 1", bus.frame); end
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL b2b_pending_hold got %b want 1", bus.pending); end
    run_to(32);
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL b2b_pending_clr got %b want 0", bus.pending); end
    run_to(33);
    checks++; if (bus.seg !== 7'b0010010) begin errors++; $display("FAIL b2b_second_seg got %b want 0010010", bus.seg); end
  endtask

  task automatic test_leading_zero();
    do_reset();
    load_now(16'h0050, 4'b0101);
    start_scan();
    run_to(17);
    checks++; if (bus.seg !== 7'b0000001) begin errors++; $display("FAIL lz_d0_seg got %b want 0000001", bus.seg); end
    checks++; if (bus.dp !== 1'b0) begin errors++; $display("FAIL lz_d0_dp got %b want 0", bus.dp); end
    run_to(21);
    checks++; if (bus.seg !== 7'b0100100) begin errors++; $display("FAIL lz_d1_seg got %b want 0100100", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL lz_d1_dp got %b want 1", bus.dp); end
    run_to(25);
    checks++; if (bus.seg !== LZ_SEG) begin errors++; $display("FAIL lz_d2_seg got %b want %b", bus.seg, LZ_SEG); end
    checks++; if (bus.dp !== 1'b0) begin errors++; $display("FAIL lz_d2_dp got %b want 0", bus.dp); end
    run_to(29);
    checks++; if (bus.seg !== LZ_SEG) begin errors++; $display("FAIL lz_d3_seg got %b want %b", bus.seg, LZ_SEG); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL lz_d3_dp got %b want 1", bus.dp); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_invalid_enable();
    test_back_to_back();
    test_leading_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV, default 1000, clk cycles per digit slot (legal >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  scan enable; low = display blanked, scan frozen.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing bcd/dp_in.
REQ-007 SHALL have port bcd  input  4*DIGITS  digit codes, digit 0 in bits [3:0] (least significant).
REQ-008 SHALL have port dp_in  input  DIGITS  decimal point per digit, 1 = lit.
REQ-009 SHALL have port seg  output  7  segments a..g on bits 6..0, active-low, registered.
REQ-010 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-011 SHALL have port an  output  DIGITS  digit select, active-low one-hot, registered.
REQ-012 SHALL have port pending  output  1  captured data not yet displayed.
REQ-013 SHALL have port frame  output  1  one-cycle pulse at digit-index wrap.

Function
REQ-014 SHALL keep a prescaler counting 0..DIV-1 while en=1; on count DIV-1 it wraps to 0 and the digit index advances.
REQ-015 SHALL wrap the digit index from DIGITS-1 to 0; that cycle asserts frame for exactly one cycle.
REQ-016 SHALL capture bcd and dp_in into a shadow register on load=1 and set pending; a load while pending overwrites the shadow (last wins).
REQ-017 SHALL copy shadow to the active register only at a frame wrap when pending=1, clearing pending; no mid-frame change (tear-free).
REQ-018 SHALL, on load coinciding with a wrap, transfer the old shadow (if pending) to active, store the new data in shadow, and leave pending=1.
REQ-019 SHALL drive an with a 0 only at the current index, and seg/dp for that digit's active code, one cycle after the index changes.
REQ-020 SHALL map codes 0..9 to seg 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100.
REQ-021 SHALL map codes 10..15 to seg 1111111 (blank); no latched/undefined output for any code.
REQ-022 SHALL, while en=0, hold prescaler and index, drive an all-ones, seg 1111111, dp 1, frame 0; load and pending still operate.
REQ-023 SHALL resume scanning from the held index and prescaler value one cycle after en returns high.

Reset
REQ-024 SHALL on rst asynchronously set prescaler 0, index 0, pending 0, frame 0, active and shadow codes all 4'hF, dp bits 0.
REQ-025 SHALL on rst drive an all-ones, seg 1111111, dp 1; rst mid-frame discards pending data.

Configuration
REQ-026 SHALL compile leading-zero blanking when SEG_LEADING_ZERO_BLANK_EN is defined: a digit with code 0 and all more-significant digits 0 is blanked, digit 0 never blanked, dp unaffected.
REQ-027 SHALL, without SEG_LEADING_ZERO_BLANK_EN, display every code 0 as "0".

Structure
REQ-028 SHALL place segment constants (SEG_0..SEG_9, SEG_BLANK) and the 4-bit code type in shared package seg_pkg.
REQ-029 SHALL implement code-to-segment mapping in combinational sub-module bcd_seg_lut, instantiated once on the selected digit.

Verification (DIGITS=4, DIV=4)
REQ-030 SHALL check reset: rst=1 -> an=1111, seg=1111111, dp=1, pending=0; after release and en=1, all digits blank (code F).
REQ-031 SHALL check scan: en=1 -> an cycles 1110,1101,1011,0111 each held 4 clk, frame pulses once every 16 clk.
REQ-032 SHALL check load: bcd=16'h1234 mid-frame -> pending=1, old data until wrap, next frame digit0 seg=1001100, digit3 seg=1001111, pending=0.
REQ-033 SHALL check invalid/enable: bcd=16'hA9B0 -> digits 1,3 seg=1111111; en=0 -> an=1111 and index holds, resume same digit.
REQ-034 SHALL check simultaneous load at wrap: pending shadow 16'h1111, load 16'h2222 on frame cycle -> 1111 shown, pending=1, 2222 next frame.
REQ-035 SHALL check macro: bcd=16'h0050 -> with SEG_LEADING_ZERO_BLANK_EN digits 3,2 blank, digit0 shows 0; without, all four lit.
